// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants: well-known register indices and defaults.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mips_pkg;

  localparam int          REG_ZERO         = 0;
  localparam int          REG_SP           = 29;
  localparam int          REG_RA           = 31;
  localparam int          DEF_DATA_WIDTH   = 32;
  localparam int          DEF_ADDR_WIDTH   = 5;
  localparam logic [31:0] DEF_SP_RESET     = 32'h7FFF_EFFC;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for multi-cycle producers, plus a population count.
// Latency: bits and count update on the clk edge after PendSet / RegWrite.
// Backpressure: none; every set/clear request is accepted each cycle.
// Ports: clk, reset (async, high); PendSet/PendRegister set a bit;
//        RegWrite/WriteRegister clear a bit; pendBits, PendCount are registered.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PendSet,
  input  logic [ADDR_WIDTH-1:0]        PendRegister,
  input  logic                         RegWrite,
  input  logic [ADDR_WIDTH-1:0]        WriteRegister,
  output logic [(2**ADDR_WIDTH)-1:0]   pendBits,
  output logic [ADDR_WIDTH:0]          PendCount
);

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic setVld;
  logic clrVld;
  logic sameIdx;
  logic inc;
  logic dec;

  // Register 0 is never tracked.
  assign setVld  = PendSet && (PendRegister != '0);
  assign clrVld  = RegWrite && (WriteRegister != '0);
  assign sameIdx = (PendRegister == WriteRegister);

  // The count follows the real population: a set only adds if the bit was
  // clear, a clear only subtracts if the bit was set and no set overrides it.
  assign inc = setVld && !pendBits[PendRegister];
  assign dec = clrVld && pendBits[WriteRegister] && !(setVld && sameIdx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pendBits  <= '0;
      PendCount <= '0;
    end else begin
      if (clrVld) pendBits[WriteRegister] <= 1'b0;
      // Issued after the clear so a newer producer on the same index wins.
      if (setVld) pendBits[PendRegister] <= 1'b1;
      case ({inc, dec})
        2'b10:   PendCount <= PendCount + ONE;
        2'b01:   PendCount <= PendCount - ONE;
        default: PendCount <= PendCount;
      endcase
    end
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// Decode-stage MIPS register file with write-to-read bypass and pending scoreboard.
// Latency: reads combinational; writes visible same cycle (BYPASS=1) or next cycle.
// Backpressure: none; consumers stall on Pending1/Pending2 via the hazard unit.
// Ports: clk, reset (async, high); RegWrite/WriteRegister/WriteData write port;
//        ReadRegisterN -> ReadDataN, PendingN; PendSet/PendRegister; PendCount.
module register_file_scoreboard
  import mips_pkg::*;
#(
  parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int          SP_INDEX   = REG_SP,
  parameter logic [31:0] SP_RESET   = DEF_SP_RESET,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  PendSet,
  input  logic [ADDR_WIDTH-1:0] PendRegister,
  output logic                  Pending1,
  output logic                  Pending2,
  output logic [ADDR_WIDTH:0]   PendCount
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pendBits;
  logic                  bypass1;
  logic                  bypass2;

  genvar i;
  generate
    for (i = 0; i < NUM_REGS; i++) begin : gReg
      if (i == REG_ZERO) begin : gZero
        assign regs[i] = '0;
      end else begin : gStore
        localparam logic [DATA_WIDTH-1:0] RESET_VAL =
          (i == SP_INDEX) ? DATA_WIDTH'(SP_RESET) : '0;
        logic [DATA_WIDTH-1:0] q;
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            q <= RESET_VAL;
          end else if (RegWrite && (WriteRegister == ADDR_WIDTH'(i))) begin
            q <= WriteData;
          end
        end
        assign regs[i] = q;
      end
    end
  endgenerate

  // Forwarding is suppressed during reset so reads show the reset image only.
  assign bypass1 = BYPASS && !reset && RegWrite &&
                   (WriteRegister == ReadRegister1) && (ReadRegister1 != '0);
  assign bypass2 = BYPASS && !reset && RegWrite &&
                   (WriteRegister == ReadRegister2) && (ReadRegister2 != '0);

  assign ReadData1 = bypass1 ? WriteData : regs[ReadRegister1];
  assign ReadData2 = bypass2 ? WriteData : regs[ReadRegister2];

  // A forwarded value is the long-awaited result, so it is no longer pending.
  assign Pending1 = pendBits[ReadRegister1] && !bypass1;
  assign Pending2 = pendBits[ReadRegister2] && !bypass2;

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) uScoreboard (
    .clk           (clk),
    .reset         (reset),
    .PendSet       (PendSet),
    .PendRegister  (PendRegister),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .pendBits      (pendBits),
    .PendCount     (PendCount)
  );

endmodule

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic        PendSet;
  logic [4:0]  PendRegister;

  logic [31:0] rd1, rd2, nbRd1, nbRd2;
  logic        p1, p2, nbP1, nbP2;
  logic [5:0]  pc, nbPc;

  int checks = 0;
  int fails  = 0;

  register_file_scoreboard #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1), .ReadData2(rd2), .PendSet(PendSet), .PendRegister(PendRegister),
    .Pending1(p1), .Pending2(p2), .PendCount(pc)
  );

  register_file_scoreboard #(.BYPASS(1'b0)) dutNb (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(nbRd1), .ReadData2(nbRd2), .PendSet(PendSet), .PendRegister(PendRegister),
    .Pending1(nbP1), .Pending2(nbP2), .PendCount(nbPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 32'h0;
    PendSet       = 1'b0;
    PendRegister  = 5'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    ReadRegister1 = 5'd29;
    ReadRegister2 = 5'd5;
    #1;
    checks++; if (rd1 !== 32'h7FFF_EFFC) begin fails++; $display("FAIL reset_sp: got %h expected 7fffeffc", rd1); end
    checks++; if (rd2 !== 32'h0) begin fails++; $display("FAIL reset_r5: got %h expected 0", rd2); end
    checks++; if ({p1, p2} !== 2'b00) begin fails++; $display("FAIL reset_pending: got %b expected 00", {p1, p2}); end
    checks++; if (pc !== 6'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", pc); end
    checks++; if (nbRd1 !== 32'h7FFF_EFFC) begin fails++; $display("FAIL reset_sp_nb: got %h expected 7fffeffc", nbRd1); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd8; WriteData = 32'hDEAD_BEEF;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'h1;
    ReadRegister1 = 5'd8; ReadRegister2 = 5'd8;
    #1;
    checks++; if (rd1 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_r8_p1: got %h expected deadbeef", rd1); end
    checks++; if (rd2 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_r8_p2: got %h expected deadbeef", rd2); end
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'(REG_RA); WriteData = 32'hA5A5_0001;
    ReadRegister1 = 5'd0;
    #1;
    checks++; if (rd1 !== 32'h0) begin fails++; $display("FAIL wr_r0: got %h expected 0", rd1); end
    checks++; if (nbRd1 !== 32'h0) begin fails++; $display("FAIL wr_r0_nb: got %h expected 0", nbRd1); end
    @(negedge clk);
    idle();
    ReadRegister2 = 5'(REG_RA);
    #1;
    checks++; if (rd2 !== 32'hA5A5_0001) begin fails++; $display("FAIL wr_r31: got %h expected a5a50001", rd2); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'h1234;
    ReadRegister2 = 5'd9;
    #1;
    checks++; if (rd2 !== 32'h1234) begin fails++; $display("FAIL bypass_on: got %h expected 1234", rd2); end
    checks++; if (nbRd2 !== 32'h0) begin fails++; $display("FAIL bypass_off_same: got %h expected 0", nbRd2); end
    @(posedge clk);
    #1;
    checks++; if (nbRd2 !== 32'h1234) begin fails++; $display("FAIL bypass_off_next: got %h expected 1234", nbRd2); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    PendSet = 1'b1; PendRegister = 5'd10;
    @(negedge clk);
    idle();
    ReadRegister1 = 5'd10;
    #1;
    checks++; if (p1 !== 1'b1) begin fails++; $display("FAIL sb_pend_set: got %b expected 1", p1); end
    checks++; if (pc !== 6'd1) begin fails++; $display("FAIL sb_count_1: got %0d expected 1", pc); end
    RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 32'h55;
    #1;
    checks++; if (p1 !== 1'b0) begin fails++; $display("FAIL sb_pend_bypass: got %b expected 0", p1); end
    checks++; if (rd1 !== 32'h55) begin fails++; $display("FAIL sb_data_bypass: got %h expected 55", rd1); end
    checks++; if (nbP1 !== 1'b1) begin fails++; $display("FAIL sb_pend_nobypass: got %b expected 1", nbP1); end
    @(posedge clk);
    #1;
    checks++; if (pc !== 6'd0) begin fails++; $display("FAIL sb_count_0: got %0d expected 0", pc); end
    @(negedge clk);
    idle();
    #1;
    checks++; if ({p1, nbP1} !== 2'b00) begin fails++; $display("FAIL sb_cleared: got %b expected 00", {p1, nbP1}); end
  endtask

  task automatic test_simultaneous();
    // r11 pending, then a newer producer issues while the old result writes back.
    @(negedge clk);
    PendSet = 1'b1; PendRegister = 5'd11;
    @(negedge clk);
    PendSet = 1'b1; PendRegister = 5'd11;
    RegWrite = 1'b1; WriteRegister = 5'd11; WriteData = 32'h77;
    @(negedge clk);
    idle();
    ReadRegister1 = 5'd11;
    #1;
    checks++; if (p1 !== 1'b1) begin fails++; $display("FAIL sim_same_pend: got %b expected 1", p1); end
    checks++; if (rd1 !== 32'h77) begin fails++; $display("FAIL sim_same_data: got %h expected 77", rd1); end
    checks++; if (pc !== 6'd1) begin fails++; $display("FAIL sim_same_count: got %0d expected 1", pc); end
    // r13 pending, then set r12 while r13 writes back.
    PendSet = 1'b1; PendRegister = 5'd13;
    @(negedge clk);
    PendSet = 1'b1; PendRegister = 5'd12;
    RegWrite = 1'b1; WriteRegister = 5'd13; WriteData = 32'h13;
    #1;
    checks++; if (pc !== 6'd2) begin fails++; $display("FAIL sim_diff_before: got %0d expected 2", pc); end
    @(negedge clk);
    idle();
    ReadRegister1 = 5'd12; ReadRegister2 = 5'd13;
    #1;
    checks++; if (pc !== 6'd2) begin fails++; $display("FAIL sim_diff_count: got %0d expected 2", pc); end
    checks++; if ({p1, p2} !== 2'b10) begin fails++; $display("FAIL sim_diff_pend: got %b expected 10", {p1, p2}); end
    // Re-setting a pending register and setting r0 both leave the count alone.
    PendSet = 1'b1; PendRegister = 5'd12;
    @(negedge clk);
    PendSet = 1'b1; PendRegister = 5'd0;
    @(negedge clk);
    idle();
    ReadRegister1 = 5'd0;
    #1;
    checks++; if (pc !== 6'd2) begin fails++; $display("FAIL sim_r0_count: got %0d expected 2", pc); end
    checks++; if ({p1, rd1} !== 33'h0) begin fails++; $display("FAIL sim_r0_state: got %b/%h expected 0/0", p1, rd1); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    PendSet = 1'b1; PendRegister = 5'd14;
    RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'h7;
    @(negedge clk);
    idle();
    ReadRegister1 = 5'd4; ReadRegister2 = 5'd29;
    #1;
    checks++; if (pc !== 6'd3) begin fails++; $display("FAIL ar_count_before: got %0d expected 3", pc); end
    checks++; if (rd1 !== 32'h7) begin fails++; $display("FAIL ar_r4_before: got %h expected 7", rd1); end
    // In-flight write and set that the reset must discard.
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'h9;
    PendSet = 1'b1; PendRegister = 5'd15;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (pc !== 6'd0) begin fails++; $display("FAIL ar_count_now: got %0d expected 0", pc); end
    checks++; if (rd1 !== 32'h0) begin fails++; $display("FAIL ar_r4_now: got %h expected 0", rd1); end
    checks++; if (rd2 !== 32'h7FFF_EFFC) begin fails++; $display("FAIL ar_sp_now: got %h expected 7fffeffc", rd2); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd15;
    #1;
    checks++; if (rd1 !== 32'h0) begin fails++; $display("FAIL ar_r5_dropped: got %h expected 0", rd1); end
    checks++; if ({p2, pc, nbPc} !== 13'h0) begin fails++; $display("FAIL ar_pend_dropped: got %b/%0d/%0d expected 0/0/0", p2, pc, nbPc); end
  endtask

  initial begin
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
